// File: rtl/ppc_display_scanner_pkg.sv
// Shared constants for the ping-pong counter display stage: active-low
// seven-segment glyphs, anode patterns and the scan-slot enumeration.
package ppc_disp_pkg;

  localparam logic [6:0] GLYPH_0    = 7'b0000001;
  localparam logic [6:0] GLYPH_1    = 7'b1001111;
  localparam logic [6:0] GLYPH_2    = 7'b0010010;
  localparam logic [6:0] GLYPH_3    = 7'b0000110;
  localparam logic [6:0] GLYPH_4    = 7'b1001100;
  localparam logic [6:0] GLYPH_5    = 7'b0100100;
  localparam logic [6:0] GLYPH_6    = 7'b0100000;
  localparam logic [6:0] GLYPH_7    = 7'b0001111;
  localparam logic [6:0] GLYPH_8    = 7'b0000000;
  localparam logic [6:0] GLYPH_9    = 7'b0000100;
  localparam logic [6:0] GLYPH_UP   = 7'b0011101;
  localparam logic [6:0] GLYPH_DOWN = 7'b1100011;
  localparam logic [6:0] GLYPH_OFF  = 7'b1111111;

  // AN_Dn enables physical digit n; digit 3 is the leftmost position.
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SCAN_TENS   = 2'd0,
    SCAN_ONES   = 2'd1,
    SCAN_DIR_HI = 2'd2,
    SCAN_DIR_LO = 2'd3
  } scan_idx_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_OFF;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/ppc_display_scanner_bcd_seg_decode.sv
// Splits a 0..15 value into decimal tens/ones and returns both as
// active-low seven-segment glyphs. Purely combinational.
module bcd_seg_decode
  import ppc_disp_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] tens_seg,
  output logic [6:0] ones_seg
);

  logic       ge_ten;
  logic [3:0] ones;

  // The leading zero is deliberately shown rather than blanked.
  always_comb begin
    ge_ten   = (value >= 4'd10);
    ones     = ge_ten ? (value - 4'd10) : value;
    tens_seg = digit_glyph(ge_ten ? 4'd1 : 4'd0);
    ones_seg = digit_glyph(ones);
  end

endmodule

// File: rtl/ppc_display_scanner.sv
// Four-digit multiplexed display scanner: count as two decimal digits on the
// left, direction glyph on the right, inputs sampled once per frame.
module ppc_display_scanner
  import ppc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 262144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       direction,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int            PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  scan_idx_t     idx;
  scan_idx_t     idx_nxt;
  logic          frame_wrap;
  logic          wrap_d;
  logic [3:0]    sh_val;
  logic          sh_dir;
  logic [6:0]    tens_seg;
  logic [6:0]    ones_seg;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign tick       = (pcnt == PCNT_MAX);
  assign frame_wrap = tick && (idx == SCAN_DIR_LO);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx <= SCAN_TENS;
    end else begin
      idx <= idx_nxt;
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (tick) begin
      case (idx)
        SCAN_TENS:   idx_nxt = SCAN_ONES;
        SCAN_ONES:   idx_nxt = SCAN_DIR_HI;
        SCAN_DIR_HI: idx_nxt = SCAN_DIR_LO;
        SCAN_DIR_LO: idx_nxt = SCAN_TENS;
      endcase
    end
  end

  // Sampling only on the 3->0 wrap keeps every frame internally consistent.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sh_val <= 4'd0;
      sh_dir <= 1'b1;
    end else if (frame_wrap) begin
      sh_val <= value;
      sh_dir <= direction;
    end
  end

  bcd_seg_decode u_decode (
    .value    (sh_val),
    .tens_seg (tens_seg),
    .ones_seg (ones_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = GLYPH_OFF;
    if (!blank) begin
      case (idx)
        SCAN_TENS: begin
          an_nxt  = AN_D3;
          seg_nxt = tens_seg;
        end
        SCAN_ONES: begin
          an_nxt  = AN_D2;
          seg_nxt = ones_seg;
        end
        SCAN_DIR_HI: begin
          an_nxt  = AN_D1;
          seg_nxt = sh_dir ? GLYPH_UP : GLYPH_DOWN;
        end
        SCAN_DIR_LO: begin
          an_nxt  = AN_D0;
          seg_nxt = sh_dir ? GLYPH_UP : GLYPH_DOWN;
        end
      endcase
    end
  end

  // frame_start is delayed twice so it lines up with the registered anodes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      an          <= AN_OFF;
      seg         <= GLYPH_OFF;
      wrap_d      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      wrap_d      <= frame_wrap;
      frame_start <= wrap_d;
    end
  end

endmodule

// File: tb/tb_ppc_display_scanner.sv
// Scoreboard bench for ppc_display_scanner: an edge-indexed frame model
// predicts an/seg/frame_start, and a negedge monitor pops and compares.
module tb_ppc_display_scanner;

  localparam int RDIV  = 4;
  localparam int FRAME = 4 * RDIV;

  localparam logic [6:0] DIG [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] UP_G  = 7'b0011101;
  localparam logic [6:0] DN_G  = 7'b1100011;
  localparam logic [6:0] OFF_G = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] value = 4'd0;
  logic       direction = 1'b1;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  ppc_display_scanner #(.REFRESH_DIV(RDIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .direction   (direction),
    .blank       (blank),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
    int         edge_n;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_active = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int sched_v  [32];
  bit sched_d  [32];
  int sched_sw [32];
  int load_v   [32];
  bit load_d   [32];

  task automatic checkOutput(input string name, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_fs);
    checks++;
    if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
      errors++;
      $display("[TB] FAIL %s: got an=%b seg=%b fs=%b, expected an=%b seg=%b fs=%b",
               name, an, seg, frame_start, exp_an, exp_seg, exp_fs);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic d, input logic b);
    value     = v;
    direction = d;
    blank     = b;
  endtask

  // Edge n counts clock edges since reset release; frame k spans edges
  // 16k+1..16k+16 and shows what was sampled at edge 16k.
  function automatic exp_t modelEdge(input int n, input logic b);
    exp_t e;
    int   slot;
    int   k;
    int   v;
    bit   d;
    slot     = ((n - 1) / RDIV) % 4;
    k        = (n - 1) / FRAME;
    v        = (k == 0) ? 0 : load_v[k];
    d        = (k == 0) ? 1'b1 : load_d[k];
    e.edge_n = n;
    e.fs     = (n > 1) && (((n - 1) % FRAME) == 0);
    e.an     = 4'b1111;
    e.seg    = OFF_G;
    if (!b) begin
      e.an[3 - slot] = 1'b0;
      case (slot)
        0:       e.seg = DIG[v / 10];
        1:       e.seg = DIG[v % 10];
        default: e.seg = d ? UP_G : DN_G;
      endcase
    end
    return e;
  endfunction

  task automatic newSchedule(input bit directed);
    for (int k = 0; k < 32; k++) begin
      sched_v[k]  = int'($urandom_range(0, 15));
      sched_d[k]  = 1'($urandom_range(0, 1));
      sched_sw[k] = int'($urandom_range(1, FRAME));
    end
    if (directed) begin
      sched_v[1] = 12; sched_d[1] = 1'b0; sched_sw[1] = 5;
      sched_v[2] = 9;  sched_d[2] = 1'b1;
      sched_v[3] = 10; sched_d[3] = 1'b0;
      sched_v[4] = 15; sched_d[4] = 1'b1;
      sched_v[5] = 3;  sched_d[5] = 1'b1;
      sched_v[6] = 7;  sched_d[6] = 1'b1; sched_sw[6] = 1;
    end
  endtask

  // Inputs before the switch offset are junk that must never reach the display.
  task automatic driveForEdge(input int m, input bit directed);
    int   k;
    int   o;
    logic b;
    k = (m + FRAME - 1) / FRAME;
    o = m - FRAME * (k - 1);
    b = 1'b0;
    if (directed && k == 3 && o >= 9 && o <= 14) b = 1'b1;
    else if (directed && k >= 8 && $urandom_range(0, 9) == 0) b = 1'b1;
    if (o >= sched_sw[k])
      applyStimulus(4'(sched_v[k]), sched_d[k], b);
    else
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), b);
  endtask

  task automatic runEdges(input int count, input bit directed);
    driveForEdge(1, directed);
    for (int n = 1; n <= count; n++) begin
      @(posedge clk);
      #1;
      if (n % FRAME == 0) begin
        load_v[n / FRAME] = int'(value);
        load_d[n / FRAME] = direction;
      end
      sb_q.push_back(modelEdge(n, blank));
      sb_active = 1'b1;
      driveForEdge(n + 1, directed);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_active) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty: got no expected entry, required one per edge");
      end else begin
        e = sb_q.pop_front();
        checkOutput($sformatf("edge%0d", e.edge_n), e.an, e.seg, e.fs);
      end
    end
  end

  initial begin
    applyStimulus(4'd0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 4'b1111, OFF_G, 1'b0);
    newSchedule(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    runEdges(FRAME * 18 + 6, 1'b1);

    @(negedge clk);
    #1;
    sb_active = 1'b0;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_async", 4'b1111, OFF_G, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_mid", 4'b1111, OFF_G, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d pending entries, required 0", sb_q.size());
      sb_q.delete();
    end

    newSchedule(1'b0);
    rst_n = 1'b0;
    runEdges(FRAME * 3, 1'b0);
    @(negedge clk);
    #1;
    sb_active = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending entries, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppc_display_scanner.md
# ppc_display_scanner

Downstream display stage for the ping-pong counter. It consumes the 4-bit count and direction flag and time-multiplexes them onto the board's 4-digit seven-segment display:
- digits 3..2 show the count as two decimal digits;
- digits 1..0 show a direction glyph.

Inputs are captured into a shadow register only at frame boundaries, so a frame never shows a torn value. All display outputs are registered.

## Interface
Parameters:
- REFRESH_DIV, 262144: clk cycles each digit is held; must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1)
- value  in  4  counter value, 0..15
- direction  in  1  1 = counting up, 0 = counting down
- blank  in  1  1 = all anodes off; scanning continues
- an  out  4  anode enables, active-low; bit 3 = leftmost digit
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low, a = MSB
- frame_start  out  1  one-cycle pulse when digit 3 is (re)selected

## Operation
- Prescaler `pcnt`:
  - counts 0..REFRESH_DIV-1, then wraps to 0;
  - `tick` = (pcnt == REFRESH_DIV-1).
- Scan index `idx`, 2 bits:
  - advances 0→1→2→3→0 on each tick;
  - idx 0 = leftmost digit.
- Shadow register {sh_val, sh_dir}:
  - loads {value, direction} on the edge where tick = 1 and idx = 3, i.e. the 3→0 transition;
  - held at all other times.
- Per-index digit map:
  - idx 0: an 0111, seg = tens glyph. Tens = 1 if sh_val ≥ 10, else 0. A leading zero is shown, not blanked.
  - idx 1: an 1011, seg = ones glyph. Ones = sh_val − 10 if sh_val ≥ 10, else sh_val.
  - idx 2: an 1101, seg = direction glyph.
  - idx 3: an 1110, seg = direction glyph.
- Direction glyphs: up = 0011101, down = 1100011.
- Digit glyphs, 0..9:
  - 0000001, 1001111, 0010010, 0000110, 1001100;
  - 0100100, 0100000, 0001111, 0000000, 0000100.
- blank = 1:
  - an = 1111 and seg = 1111111 on the next edge;
  - pcnt, idx and shadow keep running;
  - after deassertion, display resumes at the current idx, with no re-sync.
- frame_start is registered. It is 1 for exactly the cycle in which an first shows 0111 after a 3→0 transition.

## Timing
- Reset values while rst_n = 1, taking effect immediately with no clock edge:
  - pcnt = 0, idx = 0;
  - sh_val = 0, sh_dir = 1;
  - an = 1111, seg = 1111111, frame_start = 0.
- First edge after reset release: an = 0111, seg = 0000001 (tens of 0).
- Output latency: an and seg are registered from the current idx and shadow, so they lag idx by 1 cycle.
- Digit dwell: each digit is held for exactly REFRESH_DIV cycles. Frame period = 4·REFRESH_DIV cycles.
- Input update latency:
  - a new value is visible on the first cycle of the next frame;
  - worst case is 4·REFRESH_DIV + 1 cycles after it changes.
- Boundary conditions:
  - Input change on the load edge itself: the sampled (pre-edge) value is taken.
  - Reset asserted mid-frame: outputs return to reset values at once, and the partial frame is discarded.
  - blank toggled on a tick edge: the blank state applies to the newly selected digit.

## Structure
- Package `ppc_disp_pkg` holds:
  - digit glyph constants GLYPH_0..GLYPH_9;
  - GLYPH_UP, GLYPH_DOWN, GLYPH_OFF (1111111);
  - anode patterns AN_D0..AN_D3, AN_OFF (1111).
- One sub-module, `bcd_seg_decode`, is combinational:
  - input: 4-bit value;
  - outputs: tens and ones glyphs.
  - It is instantiated once on the shadow value.
- Top level contains the prescaler, scan index, shadow register and output registers.

## Test plan
All cases use REFRESH_DIV = 4.
- Reset: hold rst_n = 1 → an = 1111, seg = 1111111, frame_start = 0. Release → next edge an = 0111, seg = 0000001. Assert rst_n mid-frame with no clock → outputs return to reset values immediately.
- Cadence: free-run 32 cycles → an sequence 0111, 1011, 1101, 1110, each held exactly 4 cycles. frame_start pulses 1 cycle wide, every 16 cycles.
- Frame-synchronous update:
  - set value = 12, direction = 0 during idx 1 → current frame unchanged;
  - next frame shows 1001111, 0010010, 1100011, 1100011.
- Decimal split:
  - value = 9 → tens 0000001, ones 0000100;
  - value = 10 → 1001111, 0000001;
  - value = 15 → 1001111, 0100100.
- Blank: assert blank during idx 2 for 6 cycles → an = 1111 from the next edge. On release, display resumes on the digit idx has reached, with frame_start spacing unchanged.
- Load-edge race: change value from 3 to 7 on the exact 3→0 tick edge → new frame shows 3 (the pre-edge sample). 7 appears one frame later.
